// File: rtl/window_filter_3x3.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : window_filter_3x3
// Brief    : 3x3 sliding-window mean/min/max/centre filter, 4-edge latency.
//            Optional macro WIN_FILTER_ROUND_EN: round-to-nearest mean.
// Revision : 1.0 - initial release
// ============================================================================
module window_filter_3x3 #(
    parameter int PIC_WIDTH = 250,
    parameter int CH_NUM    = 3,
    parameter int CH_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic [CH_NUM*CH_W-1:0]   din1,
    input  logic [CH_NUM*CH_W-1:0]   din2,
    input  logic [CH_NUM*CH_W-1:0]   din3,
    input  logic [1:0]               mode,
    output logic [CH_NUM*CH_W-1:0]   dout,
    output logic                     valid_out,
    output logic                     border_out
);

    localparam int c_PW    = CH_NUM * CH_W;
    localparam int c_SW    = CH_W + 4;
    localparam int c_COL_W = $clog2(PIC_WIDTH);

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(PIC_WIDTH - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
    localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
    localparam logic [c_SW-1:0]    c_NINE     = c_SW'(9);
`ifdef WIN_FILTER_ROUND_EN
    localparam logic [c_SW-1:0]    c_RND      = c_SW'(4);
`else
    localparam logic [c_SW-1:0]    c_RND      = c_SW'(0);
`endif

    localparam logic [1:0] c_MODE_MEAN = 2'd0;
    localparam logic [1:0] c_MODE_MIN  = 2'd1;
    localparam logic [1:0] c_MODE_MAX  = 2'd2;
    localparam logic [1:0] c_MODE_CTR  = 2'd3;

    // ------------------------------------------------------------------------
    // Window shift registers and column counter
    // ------------------------------------------------------------------------
    logic [c_PW-1:0]     win_q [3][3];   // [row][age], age 0 = newest column
    logic [c_COL_W-1:0]  col_q;
    logic [c_COL_W-1:0]  col_d;
    logic                s0_valid_q;
    logic                s0_border_q;
    logic [1:0]          s0_mode_q;

    always_comb begin
        col_d = col_q;
        if (!valid_in) begin
            col_d = '0;
        end else if (col_q == c_COL_LAST) begin
            col_d = '0;
        end else begin
            col_d = col_q + c_COL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            col_q       <= '0;
            s0_valid_q  <= 1'b0;
            s0_border_q <= 1'b0;
            s0_mode_q   <= 2'd0;
        end else begin
            col_q      <= col_d;
            s0_valid_q <= valid_in;
            if (valid_in) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][2] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][0];
                end
                win_q[0][0] <= din1;
                win_q[1][0] <= din2;
                win_q[2][0] <= din3;
                s0_mode_q   <= mode;
                s0_border_q <= (col_q < c_COL_TWO);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: window snapshot, flattened row-major (index 4 is the centre)
    // ------------------------------------------------------------------------
    logic [c_PW-1:0] s1_win_q [9];
    logic            s1_valid_q;
    logic            s1_border_q;
    logic [1:0]      s1_mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                s1_win_q[k] <= '0;
            end
            s1_valid_q  <= 1'b0;
            s1_border_q <= 1'b0;
            s1_mode_q   <= 2'd0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    s1_win_q[r*3 + c] <= win_q[r][c];
                end
            end
            s1_valid_q  <= s0_valid_q;
            s1_border_q <= s0_border_q;
            s1_mode_q   <= s0_mode_q;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: per-channel sum / min / max over the nine samples
    // ------------------------------------------------------------------------
    logic [CH_NUM*c_SW-1:0] s2_sum_d;
    logic [CH_NUM*c_SW-1:0] s2_sum_q;
    logic [c_PW-1:0]        s2_min_d;
    logic [c_PW-1:0]        s2_min_q;
    logic [c_PW-1:0]        s2_max_d;
    logic [c_PW-1:0]        s2_max_q;
    logic [c_PW-1:0]        s2_ctr_q;
    logic                   s2_valid_q;
    logic                   s2_border_q;
    logic [1:0]             s2_mode_q;

    logic [c_SW-1:0]        w_acc;
    logic [CH_W-1:0]        w_smp;
    logic [CH_W-1:0]        w_lo;
    logic [CH_W-1:0]        w_hi;

    always_comb begin
        s2_sum_d = '0;
        s2_min_d = '0;
        s2_max_d = '0;
        w_acc    = '0;
        w_smp    = '0;
        w_lo     = '0;
        w_hi     = '0;
        for (int ch = 0; ch < CH_NUM; ch++) begin
            w_acc = '0;
            w_lo  = '1;
            w_hi  = '0;
            for (int k = 0; k < 9; k++) begin
                w_smp = s1_win_q[k][ch*CH_W +: CH_W];
                w_acc = w_acc + {4'b0000, w_smp};
                if (w_smp < w_lo) begin
                    w_lo = w_smp;
                end
                if (w_smp > w_hi) begin
                    w_hi = w_smp;
                end
            end
            s2_sum_d[ch*c_SW +: c_SW] = w_acc;
            s2_min_d[ch*CH_W +: CH_W] = w_lo;
            s2_max_d[ch*CH_W +: CH_W] = w_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sum_q    <= '0;
            s2_min_q    <= '0;
            s2_max_q    <= '0;
            s2_ctr_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_border_q <= 1'b0;
            s2_mode_q   <= 2'd0;
        end else begin
            s2_sum_q    <= s2_sum_d;
            s2_min_q    <= s2_min_d;
            s2_max_q    <= s2_max_d;
            s2_ctr_q    <= s1_win_q[4];
            s2_valid_q  <= s1_valid_q;
            s2_border_q <= s1_border_q;
            s2_mode_q   <= s1_mode_q;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3: divide-by-nine and mode select into the output registers
    // ------------------------------------------------------------------------
    logic [c_PW-1:0] w_mean;
    logic [c_PW-1:0] w_result;

    always_comb begin
        w_mean = '0;
        // Sum of nine CH_W samples plus rounding bias still fits c_SW bits.
        for (int ch = 0; ch < CH_NUM; ch++) begin
            w_mean[ch*CH_W +: CH_W] = CH_W'((s2_sum_q[ch*c_SW +: c_SW] + c_RND) / c_NINE);
        end
        w_result = s2_ctr_q;
        case (s2_mode_q)
            c_MODE_MEAN: w_result = w_mean;
            c_MODE_MIN:  w_result = s2_min_q;
            c_MODE_MAX:  w_result = s2_max_q;
            c_MODE_CTR:  w_result = s2_ctr_q;
            default:     w_result = s2_ctr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            valid_out  <= 1'b0;
            border_out <= 1'b0;
        end else begin
            valid_out <= s2_valid_q;
            if (s2_valid_q) begin
                dout       <= w_result;
                border_out <= s2_border_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_window_filter_3x3.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_window_filter_3x3
// Brief    : scoreboard bench for window_filter_3x3 (PIC_WIDTH=5, 3x8-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_filter_3x3;

    localparam int PIC_WIDTH = 5;
    localparam int CH_NUM    = 3;
    localparam int CH_W      = 8;
    localparam int PW        = CH_NUM * CH_W;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          valid_in = 1'b0;
    logic [PW-1:0] din1     = '0;
    logic [PW-1:0] din2     = '0;
    logic [PW-1:0] din3     = '0;
    logic [1:0]    mode     = 2'd0;
    logic [PW-1:0] dout;
    logic          valid_out;
    logic          border_out;

    window_filter_3x3 #(
        .PIC_WIDTH (PIC_WIDTH),
        .CH_NUM    (CH_NUM),
        .CH_W      (CH_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .mode       (mode),
        .dout       (dout),
        .valid_out  (valid_out),
        .border_out (border_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PW-1:0] data;
        logic          border;
        int            due;
    } exp_t;

    typedef struct {
        logic [PW-1:0] data;
        logic          border;
    } got_t;

    exp_t exp_q[$];
    got_t got_q[$];
    int   nchk   = 0;
    int   nerr   = 0;
    int   npulse = 0;

    logic [PW-1:0] mw [3][3];   // reference window [row][age]
    int            mcol = 0;
    logic [PW-1:0] last_dout   = '0;
    logic          last_border = 1'b0;
    exp_t          mon_e;
    got_t          mon_g;

    function automatic logic [PW-1:0] model_out(input logic [1:0] m);
        logic [PW-1:0] r;
        int s, lo, hi, v;
        r = '0;
        for (int ch = 0; ch < CH_NUM; ch++) begin
            s  = 0;
            lo = 255;
            hi = 0;
            for (int a = 0; a < 3; a++) begin
                for (int b = 0; b < 3; b++) begin
                    v = int'(mw[a][b][ch*CH_W +: CH_W]);
                    s = s + v;
                    if (v < lo) lo = v;
                    if (v > hi) hi = v;
                end
            end
`ifdef WIN_FILTER_ROUND_EN
            s = (s + 4) / 9;
`else
            s = s / 9;
`endif
            case (m)
                2'd0:    r[ch*CH_W +: CH_W] = 8'(s);
                2'd1:    r[ch*CH_W +: CH_W] = 8'(lo);
                2'd2:    r[ch*CH_W +: CH_W] = 8'(hi);
                default: r[ch*CH_W +: CH_W] = mw[1][1][ch*CH_W +: CH_W];
            endcase
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [PW-1:0] a, input logic [PW-1:0] b,
                         input logic [PW-1:0] c, input logic [1:0] m);
        exp_t e;
        @(posedge clk);
        #1;
        valid_in = v;
        din1     = a;
        din2     = b;
        din3     = c;
        mode     = m;
        if (v) begin
            for (int r = 0; r < 3; r++) begin
                mw[r][2] = mw[r][1];
                mw[r][1] = mw[r][0];
            end
            mw[0][0] = a;
            mw[1][0] = b;
            mw[2][0] = c;
            e.data   = model_out(m);
            e.border = (mcol < 2);
            e.due    = cyc + 4;
            exp_q.push_back(e);
            mcol = (mcol == PIC_WIDTH - 1) ? 0 : mcol + 1;
        end else begin
            mcol = 0;
        end
    endtask

    task automatic flush(input int n);
        repeat (n) drive(1'b0, '0, '0, '0, 2'd0);
    endtask

    task automatic reset_assert;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        valid_in = 1'b0;
        exp_q.delete();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                mw[r][c] = '0;
            end
        end
        mcol = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_release;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard: every valid_out pops one expected pixel; idle cycles must hold.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out) begin
                npulse++;
                mon_g.data   = dout;
                mon_g.border = border_out;
                got_q.push_back(mon_g);
                nchk++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL sb_unexpected: valid_out=1 dout=%h with nothing pending (cyc %0d)", dout, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (dout !== mon_e.data || border_out !== mon_e.border || cyc != mon_e.due) begin
                        nerr++;
                        $display("FAIL sb_pixel: got dout=%h border=%b cyc=%0d, want dout=%h border=%b cyc=%0d",
                                 dout, border_out, cyc, mon_e.data, mon_e.border, mon_e.due);
                    end
                end
            end else begin
                if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                    nchk++;
                    nerr++;
                    $display("FAIL sb_missing: no valid_out by cyc %0d, want dout=%h", cyc, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                nchk++;
                if (dout !== last_dout || border_out !== last_border) begin
                    nerr++;
                    $display("FAIL hold: got dout=%h border=%b, want held dout=%h border=%b",
                             dout, border_out, last_dout, last_border);
                end
            end
        end
        last_dout   = dout;
        last_border = border_out;
    end

    task automatic test_reset;
        reset_assert();
        nchk++;
        if (valid_out !== 1'b0 || dout !== '0 || border_out !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state: got valid=%b dout=%h border=%b, want 0/000000/0", valid_out, dout, border_out);
        end
        reset_release();
    endtask

    task automatic test_mean_flat;
        got_q.delete();
        repeat (3) drive(1'b1, 24'h101010, 24'h101010, 24'h101010, 2'd0);
        flush(6);
        nchk++;
        if (got_q.size() != 3) begin
            nerr++;
            $display("FAIL mean_flat_count: got %0d outputs, want 3", got_q.size());
        end else begin
            nchk++;
            if (got_q[2].data !== 24'h101010 || got_q[2].border !== 1'b0) begin
                nerr++;
                $display("FAIL mean_flat: got %h border=%b, want 101010 border=0", got_q[2].data, got_q[2].border);
            end
            nchk++;
            if (got_q[0].border !== 1'b1 || got_q[1].border !== 1'b1) begin
                nerr++;
                $display("FAIL mean_flat_border: got %b%b, want 11", got_q[0].border, got_q[1].border);
            end
        end
        nchk++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL mean_flat_drain: got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_mean_round;
        logic [7:0] want13, want14;
        want13 = 8'h01;
`ifdef WIN_FILTER_ROUND_EN
        want14 = 8'h02;
`else
        want14 = 8'h01;
`endif
        got_q.delete();
        drive(1'b1, 24'h1, 24'h1, 24'h1, 2'd0);
        drive(1'b1, 24'h1, 24'h1, 24'h1, 2'd0);
        drive(1'b1, 24'h1, 24'h1, 24'h5, 2'd0);
        flush(3);
        drive(1'b1, 24'h1, 24'h1, 24'h1, 2'd0);
        drive(1'b1, 24'h1, 24'h1, 24'h1, 2'd0);
        drive(1'b1, 24'h1, 24'h1, 24'h6, 2'd0);
        flush(6);
        nchk++;
        if (got_q.size() != 6) begin
            nerr++;
            $display("FAIL mean_round_count: got %0d outputs, want 6", got_q.size());
        end else begin
            nchk++;
            if (got_q[2].data[7:0] !== want13) begin
                nerr++;
                $display("FAIL mean_sum13: got %h, want %h", got_q[2].data[7:0], want13);
            end
            nchk++;
            if (got_q[5].data[7:0] !== want14) begin
                nerr++;
                $display("FAIL mean_sum14: got %h, want %h", got_q[5].data[7:0], want14);
            end
        end
    endtask

    task automatic test_minmax;
        logic [7:0] v [9];
        logic [PW-1:0] p [9];
        v = '{8'd5, 8'd0, 8'd7, 8'd3, 8'd8, 8'd1, 8'd6, 8'd2, 8'd4};
        for (int i = 0; i < 9; i++) begin
            p[i] = {8'hFF, 8'(8'h40 + 3 * i), v[i]};
        end
        got_q.delete();
        for (int m = 1; m <= 2; m++) begin
            for (int c = 0; c < 3; c++) begin
                drive(1'b1, p[3*c], p[3*c+1], p[3*c+2], 2'(m));
            end
            flush(3);
        end
        flush(3);
        nchk++;
        if (got_q.size() != 6) begin
            nerr++;
            $display("FAIL minmax_count: got %0d outputs, want 6", got_q.size());
        end else begin
            nchk++;
            if (got_q[2].data[7:0] !== 8'h00 || got_q[2].data[23:16] !== 8'hFF) begin
                nerr++;
                $display("FAIL min: got ch0=%h ch2=%h, want 00 FF", got_q[2].data[7:0], got_q[2].data[23:16]);
            end
            nchk++;
            if (got_q[5].data[7:0] !== 8'h08 || got_q[5].data[23:16] !== 8'hFF) begin
                nerr++;
                $display("FAIL max: got ch0=%h ch2=%h, want 08 FF", got_q[5].data[7:0], got_q[5].data[23:16]);
            end
        end
    endtask

    task automatic test_border_wrap;
        int nb;
        got_q.delete();
        npulse = 0;
        repeat (5) drive(1'b1, PW'($urandom), PW'($urandom), PW'($urandom), 2'($urandom_range(0, 3)));
        flush(2);
        repeat (5) drive(1'b1, PW'($urandom), PW'($urandom), PW'($urandom), 2'($urandom_range(0, 3)));
        flush(6);
        nchk++;
        if (npulse != 10) begin
            nerr++;
            $display("FAIL border_pulses: got %0d valid_out pulses, want 10", npulse);
        end
        nb = 0;
        foreach (got_q[i]) nb += int'(got_q[i].border);
        nchk++;
        if (nb != 4 || got_q.size() != 10 || got_q[0].border !== 1'b1 || got_q[5].border !== 1'b1) begin
            nerr++;
            $display("FAIL border_lines: got %0d border pixels, want 4 (cols 0,1 of each line)", nb);
        end
    endtask

    task automatic test_back_to_back;
        got_q.delete();
        npulse = 0;
        repeat (7) drive(1'b1, PW'($urandom), PW'($urandom), PW'($urandom), 2'($urandom_range(0, 3)));
        flush(6);
        nchk++;
        if (npulse != 7) begin
            nerr++;
            $display("FAIL b2b_pulses: got %0d, want 7", npulse);
        end else begin
            nchk++;
            if (got_q[4].border !== 1'b0 || got_q[5].border !== 1'b1 || got_q[6].border !== 1'b1) begin
                nerr++;
                $display("FAIL b2b_wrap: got borders %b%b%b at cols 4,0,1, want 011",
                         got_q[4].border, got_q[5].border, got_q[6].border);
            end
        end
    endtask

    task automatic test_mode_toggle;
        got_q.delete();
        repeat (3) drive(1'b1, 24'h090909, 24'h090909, 24'h090909, 2'd0);
        drive(1'b1, 24'h121212, 24'h121212, 24'h121212, 2'd0);
        drive(1'b1, 24'h121212, 24'h121212, 24'h121212, 2'd3);
        flush(6);
        nchk++;
        if (got_q.size() != 5) begin
            nerr++;
            $display("FAIL toggle_count: got %0d outputs, want 5", got_q.size());
        end else begin
            nchk++;
            if (got_q[3].data !== 24'h0C0C0C || got_q[4].data !== 24'h121212) begin
                nerr++;
                $display("FAIL toggle: got %h then %h, want 0c0c0c then 121212", got_q[3].data, got_q[4].data);
            end
        end
    endtask

    task automatic test_reset_midline;
        got_q.delete();
        repeat (4) drive(1'b1, PW'($urandom), PW'($urandom), PW'($urandom), 2'd0);
        reset_assert();
        nchk++;
        if (valid_out !== 1'b0 || dout !== '0 || border_out !== 1'b0) begin
            nerr++;
            $display("FAIL midline_reset: got valid=%b dout=%h border=%b, want 0/000000/0", valid_out, dout, border_out);
        end
        reset_release();
        repeat (3) drive(1'b1, 24'h303030, 24'h303030, 24'h303030, 2'd3);
        flush(6);
        nchk++;
        if (got_q.size() != 3) begin
            nerr++;
            $display("FAIL midline_count: got %0d outputs, want 3", got_q.size());
        end else begin
            nchk++;
            if (got_q[0].border !== 1'b1 || got_q[1].border !== 1'b1 || got_q[2].border !== 1'b0) begin
                nerr++;
                $display("FAIL midline_border: got %b%b%b, want 110",
                         got_q[0].border, got_q[1].border, got_q[2].border);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                mw[r][c] = '0;
            end
        end
        test_reset();
        test_mean_flat();
        test_mean_round();
        test_minmax();
        test_border_wrap();
        test_back_to_back();
        test_mode_toggle();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete by cyc %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
